// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings and line constants for uart_word_io.
// Holds the read/write FSM state types and the serialiser state type.
package uart_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_POP,
    R_DONE
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_PUSH,
    W_DONE
  } wr_state_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } ser_state_t;

  localparam logic UART_IDLE = 1'b1;

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: DEPTH-entry byte FIFO, head entry shown combinationally on dout.
// Ports: push/din write, pop/dout read, count/full/empty status; async active-low reset.
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == NW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is refused even if a pop happens alongside.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + NW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - NW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_word_io.sv
// uart_word_io: word-wide UART bridge with own rx/tx serialisers and byte FIFOs.
// Ports: ren/rdata/rbusy/rdone read, wen/wdata/wbusy/wdone write, rx/tx line, sticky errors.
module uart_word_io
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int WORD_BYTES  = 4,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    ren,
  output logic [8*WORD_BYTES-1:0] rdata,
  output logic                    rbusy,
  output logic                    rdone,
  input  logic                    wen,
  input  logic [8*WORD_BYTES-1:0] wdata,
  output logic                    wbusy,
  output logic                    wdone,
  input  logic                    clr_err,
  output logic                    rx_overrun,
  output logic                    frame_err,
  input  logic                    rx,
  output logic                    tx
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = 8 * WORD_BYTES;

  localparam logic [CW-1:0] BIT_END   = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END  = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(WORD_BYTES - 1);
  localparam logic [NW-1:0] WORD_CNT  = NW'(WORD_BYTES);
  localparam logic [NW-1:0] DEPTH_CNT = NW'(FIFO_DEPTH);

  // FIFO hookup
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_dout;
  logic [NW-1:0] rx_count;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_din, tx_dout;
  logic [NW-1:0] tx_count;

  // rx serialiser
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  ser_state_t    rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_done, frame_ev, ovr_ev;
  logic          rx_overrun_q, rx_overrun_d;
  logic          frame_err_q, frame_err_d;

  // read FSM
  rd_state_t     rd_st_q, rd_st_d;
  logic [2:0]    rd_idx_q, rd_idx_d;
  logic [WW-1:0] rdata_q, rdata_d;

  // write FSM
  wr_state_t     wr_st_q, wr_st_d;
  logic [2:0]    wr_idx_q, wr_idx_d;
  logic [WW-1:0] wdata_q, wdata_d;

  // tx serialiser
  ser_state_t    tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_push),
    .din   (rx_sh_q),
    .pop   (rx_pop),
    .dout  (rx_dout),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_push),
    .din   (tx_din),
    .pop   (tx_pop),
    .dout  (tx_dout),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // ---------------- rx serialiser ----------------
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q + CW'(1);
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_done  = 1'b0;
    frame_ev = 1'b0;
    unique case (rx_st_q)
      IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_st_d = START;
      end
      START: begin
        // Mid start bit: a high line means the edge was a glitch.
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = STOP;
        end
      end
      STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_st_d  = IDLE;
          if (rx_s2_q) rx_done = 1'b1;
          else         frame_ev = 1'b1;
        end
      end
      default: rx_st_d = IDLE;
    endcase
  end

  assign rx_push = rx_done && !rx_full;
  assign ovr_ev  = rx_done && rx_full;

  // A new error event wins over a same-cycle clear.
  assign rx_overrun_d = (rx_overrun_q && !clr_err) || ovr_ev;
  assign frame_err_d  = (frame_err_q && !clr_err) || frame_ev;

  // ---------------- read FSM ----------------
  always_comb begin
    rd_st_d  = rd_st_q;
    rd_idx_d = rd_idx_q;
    rdata_d  = rdata_q;
    rx_pop   = 1'b0;
    unique case (rd_st_q)
      R_IDLE: begin
        rd_idx_d = '0;
        if (ren) rd_st_d = R_WAIT;
      end
      R_WAIT: begin
        if (rx_count >= WORD_CNT) rd_st_d = R_POP;
      end
      R_POP: begin
        rx_pop                   = !rx_empty;
        rdata_d[8*rd_idx_q +: 8] = rx_dout;
        rd_idx_d                 = rd_idx_q + 3'd1;
        if (rd_idx_q == LAST_IDX) rd_st_d = R_DONE;
      end
      R_DONE: rd_st_d = R_IDLE;
      default: rd_st_d = R_IDLE;
    endcase
  end

  // ---------------- write FSM ----------------
  always_comb begin
    wr_st_d  = wr_st_q;
    wr_idx_d = wr_idx_q;
    wdata_d  = wdata_q;
    tx_push  = 1'b0;
    unique case (wr_st_q)
      W_IDLE: begin
        wr_idx_d = '0;
        if (wen) begin
          wdata_d = wdata;
          wr_st_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if ((DEPTH_CNT - tx_count) >= WORD_CNT) wr_st_d = W_PUSH;
      end
      W_PUSH: begin
        // Word is shifted down so the low byte is always next out.
        tx_push  = !tx_full;
        wdata_d  = wdata_q >> 8;
        wr_idx_d = wr_idx_q + 3'd1;
        if (wr_idx_q == LAST_IDX) wr_st_d = W_DONE;
      end
      W_DONE: wr_st_d = W_IDLE;
      default: wr_st_d = W_IDLE;
    endcase
  end

  assign tx_din = wdata_q[7:0];

  // ---------------- tx serialiser ----------------
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q + CW'(1);
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_d     = tx_q;
    tx_pop   = 1'b0;
    unique case (tx_st_q)
      IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          tx_sh_d = tx_dout;
          tx_d    = 1'b0;
          tx_st_d = START;
        end
      end
      START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          tx_bit_d = '0;
          tx_d     = tx_sh_q[0];
          tx_st_d  = DATA;
        end
      end
      DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d    = UART_IDLE;
            tx_st_d = STOP;
          end else begin
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_d     = tx_sh_q[1];
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when more is queued.
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            tx_sh_d = tx_dout;
            tx_d    = 1'b0;
            tx_st_d = START;
          end else begin
            tx_d    = UART_IDLE;
            tx_st_d = IDLE;
          end
        end
      end
      default: tx_st_d = IDLE;
    endcase
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1_q      <= UART_IDLE;
      rx_s2_q      <= UART_IDLE;
      rx_prev_q    <= UART_IDLE;
      rx_st_q      <= IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rd_st_q      <= R_IDLE;
      rd_idx_q     <= '0;
      rdata_q      <= '0;
      wr_st_q      <= W_IDLE;
      wr_idx_q     <= '0;
      wdata_q      <= '0;
      tx_st_q      <= IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_sh_q      <= '0;
      tx_q         <= UART_IDLE;
    end else begin
      rx_s1_q      <= rx;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      rx_st_q      <= rx_st_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_sh_q      <= rx_sh_d;
      rx_overrun_q <= rx_overrun_d;
      frame_err_q  <= frame_err_d;
      rd_st_q      <= rd_st_d;
      rd_idx_q     <= rd_idx_d;
      rdata_q      <= rdata_d;
      wr_st_q      <= wr_st_d;
      wr_idx_q     <= wr_idx_d;
      wdata_q      <= wdata_d;
      tx_st_q      <= tx_st_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_sh_q      <= tx_sh_d;
      tx_q         <= tx_d;
    end
  end

  assign rdata      = rdata_q;
  assign rbusy      = (rd_st_q == R_WAIT) || (rd_st_q == R_POP);
  assign rdone      = (rd_st_q == R_DONE);
  assign wbusy      = (wr_st_q == W_WAIT) || (wr_st_q == W_PUSH);
  assign wdone      = (wr_st_q == W_DONE);
  assign rx_overrun = rx_overrun_q;
  assign frame_err  = frame_err_q;
  assign tx         = tx_q;

endmodule

// File: tb/tb_uart_word_io.sv
// tb_uart_word_io: table vectors plus scoreboards for the word UART bridge.
// Drives rx frames, decodes tx frames, checks words, flags and timing.
module tb_uart_word_io;
  localparam int CPB = 4;
  localparam int WB  = 4;
  localparam int DEP = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic        clr_err = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rbusy, rdone, wbusy, wdone;
  logic        rx_overrun, frame_err, tx;

  always #5 clk = ~clk;

  uart_word_io #(
    .CLK_PER_BIT (CPB),
    .WORD_BYTES  (WB),
    .FIFO_DEPTH  (DEP)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ren        (ren),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .rdone      (rdone),
    .wen        (wen),
    .wdata      (wdata),
    .wbusy      (wbusy),
    .wdone      (wdone),
    .clr_err    (clr_err),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err),
    .rx         (rx),
    .tx         (tx)
  );

  typedef struct {
    logic [7:0]  b [4];
    logic [31:0] word;
  } rvec_t;

  typedef struct {
    logic [31:0] wdata;
    logic [7:0]  b [4];
  } wvec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  logic [31:0] exp_rd [$];
  logic [7:0]  exp_tx [$];
  int          tx_starts [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_ren(input logic [31:0] exp, input bit expect_word);
    ren = 1'b1;
    if (expect_word) exp_rd.push_back(exp);
    @(negedge clk);
    ren = 1'b0;
  endtask

  task automatic pulse_wen(input logic [31:0] w, input logic [7:0] b [4],
                           input bit expect_bytes);
    wen   = 1'b1;
    wdata = w;
    if (expect_bytes) begin
      for (int i = 0; i < 4; i++) exp_tx.push_back(b[i]);
    end
    @(negedge clk);
    wen   = 1'b0;
    wdata = '0;
  endtask

  // Waits for rdone (is_rd) or wdone; lat counts negedges since the request.
  task automatic wait_pulse(input bit is_rd, input int bound, output int lat);
    logic s;
    lat = 1;
    s = is_rd ? rdone : wdone;
    while (!s && lat < bound) begin
      @(negedge clk);
      lat++;
      s = is_rd ? rdone : wdone;
    end
    if (!s) check(is_rd ? "rdone_timeout" : "wdone_timeout", s, 1);
  endtask

  task automatic drain_tx();
    int n = 0;
    while (exp_tx.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_tx.size() != 0) check("tx_drain_timeout", exp_tx.size(), 0);
    repeat (CPB) @(negedge clk);
  endtask

  // Read scoreboard
  always @(negedge clk) begin
    if (rdone) begin
      rd_cnt <= rd_cnt + 1;
      if (exp_rd.size() == 0) check("rd_unexpected_rdone", rdone, 0);
      else check("rdata", rdata, exp_rd.pop_front());
      check("rbusy_with_rdone", rbusy, 0);
    end
  end

  // Tx frame decoder and scoreboard; frames cut by reset are discarded.
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        logic [7:0] b;
        logic       st;
        logic       ok;
        int         t0;
        t0 = cyc;
        ok = rstn;
        repeat (CPB / 2) @(negedge clk);
        st = tx;
        ok = ok & rstn;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
          ok = ok & rstn;
        end
        repeat (CPB) @(negedge clk);
        ok = ok & rstn;
        if (ok) begin
          tx_starts.push_back(t0);
          check("tx_start_bit", st, 0);
          check("tx_stop_bit", tx, 1);
          if (exp_tx.size() == 0) check("tx_unexpected_frame", exp_tx.size(), 1);
          else check("tx_byte", b, exp_tx.pop_front());
        end
        @(negedge clk);
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle %0d, limit 60000", cyc);
    $fatal(1, "watchdog expired");
  end

  rvec_t rv [4];
  wvec_t wv [3];

  initial begin
    int lat, wl, rc0, lows;
    logic [7:0] nb [4];
    logic [7:0] cb [4];

    rv[0].b = '{8'h78, 8'h56, 8'h34, 8'h12}; rv[0].word = 32'h12345678;
    rv[1].b = '{8'h00, 8'hFF, 8'h00, 8'hFF}; rv[1].word = 32'hFF00FF00;
    rv[2].b = '{8'h01, 8'h02, 8'h03, 8'h04}; rv[2].word = 32'h04030201;
    rv[3].b = '{8'hAA, 8'h55, 8'h80, 8'h7F}; rv[3].word = 32'h7F8055AA;
    wv[0].wdata = 32'hA5C30F01; wv[0].b = '{8'h01, 8'h0F, 8'hC3, 8'hA5};
    wv[1].wdata = 32'h00FF7F80; wv[1].b = '{8'h80, 8'h7F, 8'hFF, 8'h00};
    wv[2].wdata = 32'hDEADBEEF; wv[2].b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    nb = '{8'h00, 8'h00, 8'h00, 8'h00};
    cb = '{8'h42, 8'hEE, 8'hFF, 8'hC0};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_rdata", rdata, 0);
    check("rst_rbusy", rbusy, 0);
    check("rst_rdone", rdone, 0);
    check("rst_wbusy", wbusy, 0);
    check("rst_wdone", wdone, 0);
    check("rst_overrun", rx_overrun, 0);
    check("rst_frame_err", frame_err, 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Short low glitch must not produce a byte
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (50) @(negedge clk);
    check("glitch_count", dut.u_rx_fifo.count, 0);

    // Read word vectors
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 4; k++) send_byte(rv[v].b[k], 1'b1);
      repeat (4) @(negedge clk);
      pulse_ren(rv[v].word, 1'b1);
      check("rbusy_after_ren", rbusy, 1);
      wait_pulse(1'b1, 40, lat);
      check("rd_latency", lat, 6);
      @(negedge clk);
    end

    // Write word vectors
    for (int v = 0; v < 3; v++) begin
      tx_starts.delete();
      pulse_wen(wv[v].wdata, wv[v].b, 1'b1);
      check("wbusy_after_wen", wbusy, 1);
      wait_pulse(1'b0, 40, lat);
      check("wr_latency", lat, 6);
      check("wbusy_with_wdone", wbusy, 0);
      drain_tx();
      check("tx_frames", tx_starts.size(), 4);
      if (tx_starts.size() == 4) begin
        for (int i = 1; i < 4; i++)
          check("tx_back_to_back", tx_starts[i] - tx_starts[i-1], 40);
      end
      check("tx_idle_after", tx, 1);
    end

    // Overrun: 9 bytes into an 8-deep FIFO
    for (int k = 0; k < 8; k++) send_byte(8'(k), 1'b1);
    repeat (4) @(negedge clk);
    check("no_overrun_at_full", rx_overrun, 0);
    check("rx_count_full", dut.u_rx_fifo.count, 8);
    send_byte(8'h08, 1'b1);
    repeat (4) @(negedge clk);
    check("overrun_set", rx_overrun, 1);
    check("rx_count_kept", dut.u_rx_fifo.count, 8);
    pulse_ren(32'h03020100, 1'b1);
    wait_pulse(1'b1, 40, lat);
    @(negedge clk);
    pulse_ren(32'h07060504, 1'b1);
    wait_pulse(1'b1, 40, lat);
    @(negedge clk);
    check("rx_count_drained", dut.u_rx_fifo.count, 0);
    check("overrun_sticky", rx_overrun, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("overrun_cleared", rx_overrun, 0);

    // Frame error: bad stop bit drops the byte
    send_byte(8'h55, 1'b0);
    repeat (CPB) @(negedge clk);
    send_byte(8'hAA, 1'b1);
    repeat (4) @(negedge clk);
    check("frame_err_set", frame_err, 1);
    check("frame_err_count", dut.u_rx_fifo.count, 1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    repeat (4) @(negedge clk);
    pulse_ren(32'h030201AA, 1'b1);
    wait_pulse(1'b1, 40, lat);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("frame_err_cleared", frame_err, 0);

    // Partial word waits; concurrent write completes
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    rc0 = rd_cnt;
    pulse_ren(32'h44332211, 1'b1);
    repeat (30) @(negedge clk);
    check("partial_rbusy", rbusy, 1);
    check("partial_no_rdone", rd_cnt, rc0);
    fork
      begin
        send_byte(8'h33, 1'b1);
        repeat (4) @(negedge clk);
        check("three_bytes_rbusy", rbusy, 1);
        check("three_bytes_no_rdone", rd_cnt, rc0);
        send_byte(8'h44, 1'b1);
      end
      begin
        repeat (10) @(negedge clk);
        pulse_wen(32'hC0FFEE42, cb, 1'b1);
        wait_pulse(1'b0, 40, wl);
        check("concurrent_wr_latency", wl, 6);
      end
    join
    wait_pulse(1'b1, 20, lat);
    @(negedge clk);
    check("partial_rdone_count", rd_cnt, rc0 + 1);
    drain_tx();

    // Reset in the middle of a tx frame
    send_byte(8'h0F, 1'b0);
    repeat (CPB) @(negedge clk);
    pulse_ren(32'h0, 1'b0);
    pulse_wen(32'h5A5A5A5A, nb, 1'b0);
    lat = 0;
    while (tx !== 1'b0 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("mid_tx_started", tx, 0);
    repeat (13) @(negedge clk);
    check("mid_tx_bit2", tx, 0);
    check("mid_frame_err", frame_err, 1);
    check("mid_rbusy", rbusy, 1);
    rstn = 1'b0;
    #1;
    check("arst_tx", tx, 1);
    check("arst_rbusy", rbusy, 0);
    check("arst_rdone", rdone, 0);
    check("arst_wbusy", wbusy, 0);
    check("arst_wdone", wdone, 0);
    check("arst_frame_err", frame_err, 0);
    check("arst_overrun", rx_overrun, 0);
    repeat (6) @(negedge clk);
    exp_tx.delete();
    rstn = 1'b1;
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("no_leftover_tx", lows, 0);
    check("tx_fifo_empty", dut.u_tx_fifo.count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
